// File: rtl/decode_pkg.sv
// Shared decode types: opcode table, format classes, ID/EX bundle.
// DECODE_WB_BYPASS_EN selects the register-file write bypass.
package decode_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0]  OP_NOP    = 5'b00001;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I1,
    FMT_I2,
    FMT_J,
    FMT_JAL
  } fmt_e;

  typedef enum logic {
    ST_RUN,
    ST_STALL
  } hz_state_e;

  typedef struct packed {
    fmt_e fmt;
    logic use_rs;
    logic use_rt;
    logic sign_ext;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic illegal;
  } op_info_t;

  typedef struct packed {
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [15:0] imm;
    logic [15:0] pc2;
    logic [4:0]  opcode;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        halt;
    logic        err;
  } id_ex_t;

  // flags = {use_rs, use_rt, sign_ext, reg_write, mem_read, mem_write}
  function automatic op_info_t mk(
    input fmt_e       f,
    input logic [5:0] flags
  );
    op_info_t t;
    t.fmt       = f;
    t.use_rs    = flags[5];
    t.use_rt    = flags[4];
    t.sign_ext  = flags[3];
    t.reg_write = flags[2];
    t.mem_read  = flags[1];
    t.mem_write = flags[0];
    t.illegal   = 1'b0;
    return t;
  endfunction

  function automatic op_info_t op_info(
    input logic [4:0] op
  );
    op_info_t t;
    case (op)
      5'b00000, 5'b00001:
        t = mk(FMT_J, 6'b00_0000);
      5'b00100:
        t = mk(FMT_J, 6'b00_1000);
      5'b00101:
        t = mk(FMT_I2, 6'b10_1000);
      5'b00110:
        t = mk(FMT_JAL, 6'b00_1100);
      5'b01000, 5'b01001:
        t = mk(FMT_I1, 6'b10_1100);
      5'b01010, 5'b01011:
        t = mk(FMT_I1, 6'b10_0100);
      5'b01100, 5'b01101,
      5'b01110, 5'b01111:
        t = mk(FMT_I2, 6'b10_1000);
      5'b10000:
        t = mk(FMT_I1, 6'b11_1001);
      5'b10001:
        t = mk(FMT_I1, 6'b10_1110);
      5'b10010:
        t = mk(FMT_I2, 6'b10_0100);
      5'b10100, 5'b10101,
      5'b10110, 5'b10111:
        t = mk(FMT_I1, 6'b10_0100);
      5'b11000:
        t = mk(FMT_I2, 6'b00_1100);
      5'b11001:
        t = mk(FMT_R, 6'b10_0100);
      5'b11010, 5'b11011,
      5'b11100, 5'b11101,
      5'b11110, 5'b11111:
        t = mk(FMT_R, 6'b11_0100);
      default: begin
        t = mk(FMT_J, 6'b00_0000);
        t.illegal = 1'b1;
      end
    endcase
    return t;
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 8x16 register file, two async read ports, one write port.
// DECODE_WB_BYPASS_EN forwards the write data to a matching read.
module regfile_8x16 #(
  parameter int NREGS = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [2:0]  wa_i,
  input  logic [15:0] wd_i,
  input  logic [2:0]  ra0_i,
  output logic [15:0] rd0_o,
  input  logic [2:0]  ra1_i,
  output logic [15:0] rd1_o
);

  logic [15:0] mem_q [NREGS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++)
        mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
  end

`ifdef DECODE_WB_BYPASS_EN
  assign rd0_o = (we_i && wa_i == ra0_i)
               ? wd_i : mem_q[ra0_i];
  assign rd1_o = (we_i && wa_i == ra1_i)
               ? wd_i : mem_q[ra1_i];
`else
  assign rd0_o = mem_q[ra0_i];
  assign rd1_o = mem_q[ra1_i];
`endif

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field/immediate decode, regfile read, hazards, ID/EX reg.
// DECODE_WB_BYPASS_EN removes the WB read-after-write stall.
module decode_stage
  import decode_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipeEn,
  input  logic [15:0] instr_IFID,
  input  logic [15:0] PC2_IFID,
  input  logic        halt_IFID,
  input  logic        takeBranch_EXMEM,
  input  logic        writeEn_WB,
  input  logic [2:0]  writeReg_WB,
  input  logic [15:0] writeData_WB,
  output logic [15:0] rsData_IDEX,
  output logic [15:0] rtData_IDEX,
  output logic [15:0] imm_IDEX,
  output logic [15:0] PC2_IDEX,
  output logic [4:0]  opcode_IDEX,
  output logic [2:0]  rs_IDEX,
  output logic [2:0]  rt_IDEX,
  output logic [2:0]  rd_IDEX,
  output logic        regWrite_IDEX,
  output logic        memRead_IDEX,
  output logic        memWrite_IDEX,
  output logic        halt_IDEX,
  output logic        err_IDEX,
  output logic        stallCtrl,
  output logic        startStall
);

  logic [4:0]  op;
  logic [2:0]  rs_idx;
  logic [2:0]  rt_idx;
  logic [2:0]  rd_idx;
  logic [15:0] imm;
  logic [15:0] rs_data;
  logic [15:0] rt_data;
  op_info_t    info;
  logic        load_haz;
  logic        wb_haz;
  id_ex_t      idex_q;
  id_ex_t      idex_d;
  id_ex_t      dec;
  hz_state_e   state_q;

  assign op     = instr_IFID[15:11];
  assign rs_idx = instr_IFID[10:8];
  assign rt_idx = instr_IFID[7:5];
  assign info   = op_info(op);

  regfile_8x16 #(
    .NREGS (NREGS)
  ) u_rf (
    .clk_i (clk),
    .rst_i (rst),
    .we_i  (writeEn_WB & pipeEn),
    .wa_i  (writeReg_WB),
    .wd_i  (writeData_WB),
    .ra0_i (rs_idx),
    .rd0_o (rs_data),
    .ra1_i (rt_idx),
    .rd1_o (rt_data)
  );

  always_comb begin
    rd_idx = 3'd0;
    imm    = '0;
    unique case (info.fmt)
      FMT_R: begin
        rd_idx = instr_IFID[4:2];
      end
      FMT_I1: begin
        rd_idx = instr_IFID[7:5];
        imm = {{11{info.sign_ext & instr_IFID[4]}},
               instr_IFID[4:0]};
      end
      FMT_I2: begin
        rd_idx = instr_IFID[10:8];
        imm = {{8{info.sign_ext & instr_IFID[7]}},
               instr_IFID[7:0]};
      end
      FMT_JAL: begin
        rd_idx = 3'd7;
        imm = {{5{info.sign_ext & instr_IFID[10]}},
               instr_IFID[10:0]};
      end
      default: begin
        imm = {{5{info.sign_ext & instr_IFID[10]}},
               instr_IFID[10:0]};
      end
    endcase
  end

  // Only sources the instruction really reads can create a hazard
  assign load_haz = idex_q.mem_read &
    ((info.use_rs & (idex_q.rd == rs_idx)) |
     (info.use_rt & (idex_q.rd == rt_idx)));

`ifdef DECODE_WB_BYPASS_EN
  assign wb_haz = 1'b0;
`else
  assign wb_haz = writeEn_WB &
    ((info.use_rs & (writeReg_WB == rs_idx)) |
     (info.use_rt & (writeReg_WB == rt_idx)));
`endif

  assign stallCtrl  = (load_haz | wb_haz) &
                      ~takeBranch_EXMEM;
  assign startStall = stallCtrl &
                      (state_q == ST_RUN);

  always_comb begin
    dec           = '0;
    dec.rs_data   = rs_data;
    dec.rt_data   = rt_data;
    dec.imm       = imm;
    dec.pc2       = PC2_IFID;
    dec.opcode    = op;
    dec.rs        = rs_idx;
    dec.rt        = rt_idx;
    dec.rd        = rd_idx;
    dec.reg_write = info.reg_write & ~info.illegal;
    dec.mem_read  = info.mem_read & ~info.illegal;
    dec.mem_write = info.mem_write & ~info.illegal;
    dec.halt      = halt_IFID | (instr_IFID == 16'h0000);
    dec.err       = info.illegal;
    idex_d        = dec;
    if (takeBranch_EXMEM | stallCtrl) begin
      idex_d        = '0;
      idex_d.opcode = OP_NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      idex_q <= '0;
    else if (pipeEn)
      idex_q <= idex_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else if (pipeEn) begin
      unique case (state_q)
        ST_RUN:
          if (stallCtrl) state_q <= ST_STALL;
        ST_STALL:
          if (!stallCtrl) state_q <= ST_RUN;
        default:
          state_q <= ST_RUN;
      endcase
    end
  end

  assign rsData_IDEX   = idex_q.rs_data;
  assign rtData_IDEX   = idex_q.rt_data;
  assign imm_IDEX      = idex_q.imm;
  assign PC2_IDEX      = idex_q.pc2;
  assign opcode_IDEX   = idex_q.opcode;
  assign rs_IDEX       = idex_q.rs;
  assign rt_IDEX       = idex_q.rt;
  assign rd_IDEX       = idex_q.rd;
  assign regWrite_IDEX = idex_q.reg_write;
  assign memRead_IDEX  = idex_q.mem_read;
  assign memWrite_IDEX = idex_q.mem_write;
  assign halt_IDEX     = idex_q.halt;
  assign err_IDEX      = idex_q.err;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: spec-level model compared every cycle,
// plus directed literal checks. Honors DECODE_WB_BYPASS_EN.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic        pipeEn;
  logic [15:0] instr_IFID;
  logic [15:0] PC2_IFID;
  logic        halt_IFID;
  logic        takeBranch_EXMEM;
  logic        writeEn_WB;
  logic [2:0]  writeReg_WB;
  logic [15:0] writeData_WB;
  logic [15:0] rsData_IDEX;
  logic [15:0] rtData_IDEX;
  logic [15:0] imm_IDEX;
  logic [15:0] PC2_IDEX;
  logic [4:0]  opcode_IDEX;
  logic [2:0]  rs_IDEX;
  logic [2:0]  rt_IDEX;
  logic [2:0]  rd_IDEX;
  logic        regWrite_IDEX;
  logic        memRead_IDEX;
  logic        memWrite_IDEX;
  logic        halt_IDEX;
  logic        err_IDEX;
  logic        stallCtrl;
  logic        startStall;

  decode_stage #(.NREGS(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .pipeEn           (pipeEn),
    .instr_IFID       (instr_IFID),
    .PC2_IFID         (PC2_IFID),
    .halt_IFID        (halt_IFID),
    .takeBranch_EXMEM (takeBranch_EXMEM),
    .writeEn_WB       (writeEn_WB),
    .writeReg_WB      (writeReg_WB),
    .writeData_WB     (writeData_WB),
    .rsData_IDEX      (rsData_IDEX),
    .rtData_IDEX      (rtData_IDEX),
    .imm_IDEX         (imm_IDEX),
    .PC2_IDEX         (PC2_IDEX),
    .opcode_IDEX      (opcode_IDEX),
    .rs_IDEX          (rs_IDEX),
    .rt_IDEX          (rt_IDEX),
    .rd_IDEX          (rd_IDEX),
    .regWrite_IDEX    (regWrite_IDEX),
    .memRead_IDEX     (memRead_IDEX),
    .memWrite_IDEX    (memWrite_IDEX),
    .halt_IDEX        (halt_IDEX),
    .err_IDEX         (err_IDEX),
    .stallCtrl        (stallCtrl),
    .startStall       (startStall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] rsd;
    logic [15:0] rtd;
    logic [15:0] imm;
    logic [15:0] pc2;
    logic [4:0]  op;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        h;
    logic        err;
  } bun_t;

  int checks = 0;
  int failures = 0;
  bit chk_on = 0;

  bun_t        m;
  logic [15:0] m_rf [8];
  bit          m_in_stall;

  // class: 0=R 1=I1 2=I2 3=J 4=JAL
  function automatic void minfo(
    input  logic [4:0] op,
    output int c,
    output bit urs, urt, sx, rw, mr, mw, ill
  );
    c = 3;
    {urs, urt, sx, rw, mr, mw, ill} = '0;
    if (op inside {5'd2, 5'd3, 5'd7, 5'd19})
      ill = 1;
    else if (op == 5'd4)
      sx = 1;
    else if (op == 5'd5) begin
      c = 2; urs = 1; sx = 1;
    end else if (op == 5'd6) begin
      c = 4; sx = 1; rw = 1;
    end else if (op >= 5'd8 && op <= 5'd11) begin
      c = 1; urs = 1; rw = 1; sx = (op < 5'd10);
    end else if (op >= 5'd12 && op <= 5'd15) begin
      c = 2; urs = 1; sx = 1;
    end else if (op == 5'd16) begin
      c = 1; urs = 1; urt = 1; sx = 1; mw = 1;
    end else if (op == 5'd17) begin
      c = 1; urs = 1; sx = 1; rw = 1; mr = 1;
    end else if (op == 5'd18) begin
      c = 2; urs = 1; rw = 1;
    end else if (op >= 5'd20 && op <= 5'd23) begin
      c = 1; urs = 1; rw = 1;
    end else if (op == 5'd24) begin
      c = 2; sx = 1; rw = 1;
    end else if (op == 5'd25) begin
      c = 0; urs = 1; rw = 1;
    end else if (op >= 5'd26) begin
      c = 0; urs = 1; urt = 1; rw = 1;
    end
  endfunction

  function automatic bit uses(
    input logic [15:0] i,
    input logic [2:0]  r
  );
    int c;
    bit urs, urt, sx, rw, mr, mw, ill;
    minfo(i[15:11], c, urs, urt, sx, rw, mr, mw, ill);
    return (urs && i[10:8] == r) ||
           (urt && i[7:5] == r);
  endfunction

  function automatic bit m_stall();
    bit h;
    h = m.mr && uses(instr_IFID, m.rd);
`ifndef DECODE_WB_BYPASS_EN
    h = h || (writeEn_WB &&
              uses(instr_IFID, writeReg_WB));
`endif
    return h && !takeBranch_EXMEM;
  endfunction

  function automatic logic [15:0] m_read(
    input logic [2:0] r
  );
`ifdef DECODE_WB_BYPASS_EN
    if (writeEn_WB && writeReg_WB == r)
      return writeData_WB;
`endif
    return m_rf[r];
  endfunction

  function automatic bun_t m_decode(
    input logic [15:0] i
  );
    bun_t b;
    int c, n, f;
    bit urs, urt, sx, rw, mr, mw, ill;
    minfo(i[15:11], c, urs, urt, sx, rw, mr, mw, ill);
    b     = '0;
    b.op  = i[15:11];
    b.rs  = i[10:8];
    b.rt  = i[7:5];
    b.rsd = m_read(i[10:8]);
    b.rtd = m_read(i[7:5]);
    b.pc2 = PC2_IFID;
    n = (c == 1) ? 5 : (c == 2) ? 8 : (c >= 3) ? 11 : 0;
    if (n > 0) begin
      f = int'(i) % (1 << n);
      if (sx && f >= (1 << (n - 1)))
        f = f - (1 << n);
      b.imm = 16'(f);
    end
    case (c)
      0:       b.rd = i[4:2];
      1:       b.rd = i[7:5];
      2:       b.rd = i[10:8];
      4:       b.rd = 3'd7;
      default: b.rd = 3'd0;
    endcase
    b.rw  = rw && !ill;
    b.mr  = mr && !ill;
    b.mw  = mw && !ill;
    b.err = ill;
    b.h   = halt_IFID || (i == 16'h0000);
    return b;
  endfunction

  always @(posedge clk) begin
    bit st;
    if (rst) begin
      m = '0;
      m_in_stall = 0;
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
    end else if (pipeEn) begin
      st = m_stall();
      if (takeBranch_EXMEM || st) begin
        m = '0;
        m.op = 5'd1;
      end else begin
        m = m_decode(instr_IFID);
      end
      m_in_stall = st;
      if (writeEn_WB) m_rf[writeReg_WB] = writeData_WB;
    end
  end

  always @(negedge clk) begin
    bun_t a;
    bit es;
    if (chk_on) begin
      a = {rsData_IDEX, rtData_IDEX, imm_IDEX, PC2_IDEX,
           opcode_IDEX, rs_IDEX, rt_IDEX, rd_IDEX,
           regWrite_IDEX, memRead_IDEX, memWrite_IDEX,
           halt_IDEX, err_IDEX};
      es = m_stall();
      checks++;
      if (a !== m || stallCtrl !== es ||
          startStall !== (es && !m_in_stall)) begin
        failures++;
        $display("FAIL model t=%0t got=%h st=%b ss=%b want=%h st=%b ss=%b",
                 $time, a, stallCtrl, startStall,
                 m, es, es && !m_in_stall);
      end
    end
  end

  task automatic chk(
    input string       nm,
    input logic [15:0] act,
    input logic [15:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set(
    input logic [15:0] i,
    input logic [15:0] pc
  );
    instr_IFID = i;
    PC2_IFID   = pc;
  endtask

  task automatic wb(
    input logic        en,
    input logic [2:0]  r,
    input logic [15:0] d
  );
    writeEn_WB   = en;
    writeReg_WB  = r;
    writeData_WB = d;
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [15:0] imm;
    logic [2:0]  rd;
    logic        rw;
    logic        mw;
    logic        h;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{16'hC280, 16'hFF80, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'h503F, 16'h001F, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h2400, 16'hFC00, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h3001, 16'h0001, 3'd7, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{16'h4623, 16'h0003, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'h815F, 16'hFFFF, 3'd2, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    pipeEn = 1'b1;
    halt_IFID = 1'b0;
    takeBranch_EXMEM = 1'b0;
    set(16'h0800, 16'h0000);
    wb(1'b0, 3'd0, 16'h0000);
    tick();
    chk_on = 1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_op", 16'(opcode_IDEX), 16'h0000);
    chk("rst_rsd", rsData_IDEX, 16'h0000);
    chk("rst_rw", 16'(regWrite_IDEX), 16'h0000);
    chk("rst_halt", 16'(halt_IDEX), 16'h0000);
    chk("rst_stall", 16'(stallCtrl), 16'h0000);
    chk("rst_start", 16'(startStall), 16'h0000);

    // decode ADD r1,r2,r3
    wb(1'b1, 3'd2, 16'h1234);
    tick();
    wb(1'b1, 3'd3, 16'h0001);
    tick();
    wb(1'b0, 3'd0, 16'h0000);
    set(16'hDA64, 16'h0010);
    tick();
    chk("add_rsd", rsData_IDEX, 16'h1234);
    chk("add_rtd", rtData_IDEX, 16'h0001);
    chk("add_rd", 16'(rd_IDEX), 16'h0001);
    chk("add_rw", 16'(regWrite_IDEX), 16'h0001);
    chk("add_pc2", PC2_IDEX, 16'h0010);

    // load-use: LD r4 then ADD r5,r4,r4
    set(16'h8880, 16'h0012);
    tick();
    chk("ld_mr", 16'(memRead_IDEX), 16'h0001);
    chk("ld_rd", 16'(rd_IDEX), 16'h0004);
    set(16'hDC94, 16'h0014);
    #1;
    chk("lu_stall", 16'(stallCtrl), 16'h0001);
    chk("lu_start", 16'(startStall), 16'h0001);
    tick();
    chk("lu_nop", 16'(opcode_IDEX), 16'h0001);
    chk("lu_nop_rw", 16'(regWrite_IDEX), 16'h0000);
    chk("lu_stall1", 16'(stallCtrl), 16'h0000);
    tick();
    chk("lu_add", 16'(opcode_IDEX), 16'h001B);
    chk("lu_add_rd", 16'(rd_IDEX), 16'h0005);

    // flush beats hazard
    set(16'h8880, 16'h0016);
    tick();
    set(16'hDC94, 16'h0018);
    takeBranch_EXMEM = 1'b1;
    #1;
    chk("fl_stall", 16'(stallCtrl), 16'h0000);
    chk("fl_start", 16'(startStall), 16'h0000);
    tick();
    chk("fl_nop", 16'(opcode_IDEX), 16'h0001);
    chk("fl_pc2", PC2_IDEX, 16'h0000);
    takeBranch_EXMEM = 1'b0;

    // WB write of r6 while ADDI reads r6
    set(16'h4623, 16'h001A);
    wb(1'b1, 3'd6, 16'hBEEF);
    #1;
`ifdef DECODE_WB_BYPASS_EN
    chk("byp_stall", 16'(stallCtrl), 16'h0000);
    tick();
    wb(1'b0, 3'd0, 16'h0000);
    chk("byp_rsd", rsData_IDEX, 16'hBEEF);
    chk("byp_imm", imm_IDEX, 16'h0003);
`else
    chk("wbh_stall", 16'(stallCtrl), 16'h0001);
    chk("wbh_start", 16'(startStall), 16'h0001);
    tick();
    wb(1'b0, 3'd0, 16'h0000);
    chk("wbh_nop", 16'(opcode_IDEX), 16'h0001);
    #1;
    chk("wbh_stall1", 16'(stallCtrl), 16'h0000);
    tick();
    chk("wbh_rsd", rsData_IDEX, 16'hBEEF);
`endif

    // freeze during a stall
    set(16'h8880, 16'h001C);
    tick();
    set(16'hDC94, 16'h001E);
    pipeEn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("fz_stall", 16'(stallCtrl), 16'h0001);
      chk("fz_start", 16'(startStall), 16'h0001);
      tick();
      chk("fz_op", 16'(opcode_IDEX), 16'h0011);
      chk("fz_mr", 16'(memRead_IDEX), 16'h0001);
    end
    pipeEn = 1'b1;
    #1;
    chk("fz_start_rel", 16'(startStall), 16'h0001);
    tick();
    chk("fz_nop", 16'(opcode_IDEX), 16'h0001);
    chk("fz_stall_rel", 16'(stallCtrl), 16'h0000);
    chk("fz_start_off", 16'(startStall), 16'h0000);
    tick();
    chk("fz_add", 16'(opcode_IDEX), 16'h001B);

    // reset in the middle of a stall
    set(16'h8880, 16'h0020);
    tick();
    set(16'hDC94, 16'h0022);
    #1;
    chk("rs_stall", 16'(stallCtrl), 16'h0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set(16'h0800, 16'h0000);
    #1;
    chk("rs_op", 16'(opcode_IDEX), 16'h0000);
    chk("rs_mr", 16'(memRead_IDEX), 16'h0000);
    chk("rs_stall0", 16'(stallCtrl), 16'h0000);
    chk("rs_start0", 16'(startStall), 16'h0000);
    set(16'h4623, 16'h0024);
    tick();
    chk("rs_rf", rsData_IDEX, 16'h0000);

    // r0 is an ordinary register
    set(16'h0800, 16'h0026);
    wb(1'b1, 3'd0, 16'h5555);
    tick();
    wb(1'b0, 3'd0, 16'h0000);
    set(16'h4020, 16'h0028);
    tick();
    chk("r0_rsd", rsData_IDEX, 16'h5555);

    // immediate / dest / halt table
    foreach (vecs[k]) begin
      set(vecs[k].ins, 16'h0100);
      tick();
      chk("v_imm", imm_IDEX, vecs[k].imm);
      chk("v_rd", 16'(rd_IDEX), 16'(vecs[k].rd));
      chk("v_rw", 16'(regWrite_IDEX), 16'(vecs[k].rw));
      chk("v_mw", 16'(memWrite_IDEX), 16'(vecs[k].mw));
      chk("v_halt", 16'(halt_IDEX), 16'(vecs[k].h));
      chk("v_err", 16'(err_IDEX), 16'h0000);
    end

    // halt flag from fetch, illegal opcode
    halt_IFID = 1'b1;
    set(16'hDA64, 16'h0102);
    tick();
    chk("hf_halt", 16'(halt_IDEX), 16'h0001);
    halt_IFID = 1'b0;
    set(16'h1234, 16'h0104);
    tick();
    chk("il_err", 16'(err_IDEX), 16'h0001);
    chk("il_rw", 16'(regWrite_IDEX), 16'h0000);
    chk("il_op", 16'(opcode_IDEX), 16'h0002);

    set(16'h0800, 16'h0000);
    tick();
    tick();
    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the five-stage 16-bit pipeline, directly downstream of fetch. It consumes the IF/ID bundle, decodes register indices, immediates and control bits, and reads the 8×16 register file. It detects load-use hazards, and drives `stallCtrl`/`startStall` back to fetch. It registers everything into the ID/EX pipeline register, inserting NOPs on stall and on EX/MEM branch flush.

## Interface
Parameters:
- `NREGS`, 8: register count; index width is 3.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pipeEn`  in  1  1 = pipeline advances; 0 = every register in this block holds, including the register file and the hazard FSM.
- `instr_IFID`  in  16  instruction from fetch; `16'h0800` is NOP.
- `PC2_IFID`  in  16  PC+2 of that instruction.
- `halt_IFID`  in  1  halt flag from fetch.
- `takeBranch_EXMEM`  in  1  redirect/flush request.
- `writeEn_WB`, `writeReg_WB[2:0]`, `writeData_WB[15:0]`  in  register-file write port.
- `rsData_IDEX`, `rtData_IDEX`, `imm_IDEX`, `PC2_IDEX`  out  16 each  registered operands.
- `opcode_IDEX`  out  5  registered opcode.
- `rs_IDEX`, `rt_IDEX`, `rd_IDEX`  out  3 each  registered register indices.
- `regWrite_IDEX`, `memRead_IDEX`, `memWrite_IDEX`, `halt_IDEX`, `err_IDEX`  out  1 each  registered control bits.
- `stallCtrl`  out  1  combinational; holds fetch and the IF/ID register.
- `startStall`  out  1  combinational; high only in the first cycle of a stall episode.

## Operation
- **Field decode.**
  - Opcode is `instr[15:11]`; rs is `[10:8]`; rt is `[7:5]`.
  - Format class comes from the package table.
  - Destination register by class:
    - R: `[4:2]`
    - I1: `[7:5]`
    - I2: `[10:8]`
    - JAL: constant 7
- **Immediates.**
  - I1 uses `[4:0]`, I2 uses `[7:0]`, J uses `[10:0]`.
  - Sign or zero extension is selected per opcode by the package table.
  - Results are always 16 bits.
- **Source usage.**
  - `useRs` and `useRt` come from the table.
  - A hazard only counts on a source the instruction actually reads.
- **Load-use hazard.** `loadHaz` = `memRead_IDEX` & `rd_IDEX` matches a used source of `instr_IFID`.
- **Stall.**
  - `stallCtrl` = (`loadHaz` | `wbHaz`) & ~`takeBranch_EXMEM`.
  - `wbHaz` is defined under Configuration.
- **Next ID/EX value, by priority:**
  1. `rst`: all fields 0.
  2. `pipeEn`=0: hold.
  3. `takeBranch_EXMEM` or `stallCtrl`: NOP bundle. Opcode `5'b00001`; regWrite, memRead, memWrite, halt and err all 0; data fields 0.
  4. Otherwise: the decoded bundle.
- **Halt.** `halt_IDEX` is loaded from `halt_IFID`, and also forced to 1 when `instr_IFID == 0`.
- **Illegal opcodes.** `err_IDEX` = 1 for opcodes marked illegal in the table; such an instruction has regWrite, memRead and memWrite forced to 0.
- **Register file.**
  - Written on the clock edge when `writeEn_WB & pipeEn`.
  - r0 is an ordinary register.
  - All registers reset to 0.
- **Hazard FSM.**
  - States: RUN, STALL.
  - RUN→STALL when `stallCtrl & pipeEn`.
  - STALL→RUN when `!stallCtrl & pipeEn`.
  - `startStall` = `stallCtrl` & (state==RUN).
  - Reset state is RUN.

## Timing
- Decode-to-ID/EX latency is 1 cycle.
- A load followed immediately by a dependent instruction costs exactly one bubble:
  - Cycle N: `stallCtrl`=1 and `startStall`=1.
  - Cycle N+1: ID/EX holds a NOP and `stallCtrl`=0.
  - Cycle N+2: the dependent instruction is in ID/EX.
- A flush in the same cycle as a hazard: the flush wins, `stallCtrl`=0 and a NOP is loaded.
- A stall while `pipeEn`=0: `stallCtrl` stays asserted, and `startStall` remains high until the cycle in which `pipeEn`=1.
- Reset mid-stall: the FSM returns to RUN and all outputs are 0 the cycle after `rst`.
- All register-file reads are combinational from the current state; writes become visible the next cycle, or the same cycle when bypass is enabled.

## Configuration
- **`DECODE_WB_BYPASS_EN` defined:**
  - A read whose index matches `writeReg_WB` while `writeEn_WB`=1 returns `writeData_WB` in the same cycle.
  - `wbHaz` = 0.
- **Undefined:**
  - Reads return stored contents only.
  - `wbHaz` = `writeEn_WB` & `writeReg_WB` matches a used source, which stalls one cycle until the write lands.

## Structure
- **Package `decode_pkg`:**
  - NOP constant `16'h0800`.
  - Format-class enum (R, I1, I2, J, JAL).
  - Per-opcode table: class, useRs, useRt, signExt, regWrite, memRead, memWrite, illegal.
  - FSM state enum.
- **Sub-module `regfile_8x16`:**
  - Two read ports and one write port.
  - Synchronous reset.
  - Contains the bypass `ifdef`.

## Test plan
- **Reset:** pulse `rst`, then check all `_IDEX` outputs = 0, `stallCtrl`=0, FSM=RUN.
- **Decode:** WB writes r2=`16'h1234` and r3=`16'h0001`, then ADD r1,r2,r3 → next cycle `rsData_IDEX`=`16'h1234`, `rtData_IDEX`=`16'h0001`, `rd_IDEX`=1, `regWrite_IDEX`=1.
- **Load-use:** LD r4 in ID/EX and ADD r5,r4,r4 in IF/ID → one cycle with `stallCtrl`=1 and `startStall`=1, then a NOP in ID/EX, then the ADD.
- **Flush versus hazard:** hazard plus `takeBranch_EXMEM`=1 → `stallCtrl`=0 and ID/EX = NOP.
- **Bypass:** WB writes r6=`16'hBEEF` in the same cycle an instruction reads r6.
  - With the macro: `rsData_IDEX`=`16'hBEEF`, no stall.
  - Without the macro: a one-cycle stall, then `16'hBEEF`.
- **Freeze:** hold `pipeEn`=0 for 3 cycles during a stall → outputs frozen and `startStall` held; releasing it completes a single bubble.
